// File: rtl/run_control.sv
// Run/stop/single-step controller: debounces RUN and STEP buttons, tracks HLT,
// and gates the downstream clock divider so a step releases one full CPU clock.
module run_control #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_run_n,
    input  logic i_btn_step_n,
    input  logic i_hlt,
    input  logic i_cpu_clk,
    output logic o_halt,
    output logic o_running,
    output logic o_step_done
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned N_BTN = 2;
    localparam int unsigned BTN_RUN = 0;
    localparam int unsigned BTN_STEP = 1;

    typedef enum logic [1:0] {
        S_HALTED,
        S_RUN,
        S_STEP_RISE,
        S_STEP_FALL
    } state_t;

    state_t r_state;

    logic [N_BTN-1:0] w_btn_raw;
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_deb;
    logic [N_BTN-1:0] r_evt;
    logic [CNT_W-1:0] r_cnt [N_BTN];

    logic r_cpu_prev;
    logic r_step_done;
    logic w_rise;
    logic w_fall;
    logic w_run_evt;
    logic w_step_evt;

    assign w_btn_raw = {i_btn_step_n, i_btn_run_n};

    // Per-button synchronizer, debounce counter and press-event pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_deb   <= '1;
            r_evt   <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < int'(N_BTN); i++) begin
                r_evt[i] <= 1'b0;
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_cnt[i] + CNT_W'(1) == CNT_W'(DEBOUNCE_CYCLES)) begin
                        r_deb[i] <= r_sync2[i];
                        r_cnt[i] <= '0;
                        r_evt[i] <= ~r_sync2[i];
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_run_evt  = r_evt[BTN_RUN];
    assign w_step_evt = r_evt[BTN_STEP];

    // CPU clock edge detect; the feedback clock is derived from i_clk
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cpu_prev <= 1'b0;
        end else begin
            r_cpu_prev <= i_cpu_clk;
        end
    end

    assign w_rise = i_cpu_clk & ~r_cpu_prev;
    assign w_fall = ~i_cpu_clk & r_cpu_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_HALTED;
            r_step_done <= 1'b0;
        end else begin
            r_step_done <= 1'b0;
            case (r_state)
                S_HALTED: begin
                    if (!i_hlt) begin
                        if (w_run_evt) begin
                            r_state <= S_RUN;
                        end else if (w_step_evt) begin
                            r_state <= S_STEP_RISE;
                        end
                    end
                end
                S_RUN: begin
                    if (w_run_evt || i_hlt) begin
                        r_state <= S_HALTED;
                    end
                end
                S_STEP_RISE: begin
                    if (w_rise) begin
                        r_state <= S_STEP_FALL;
                    end
                end
                S_STEP_FALL: begin
                    // Halting after the fall leaves the divider output low
                    if (w_fall) begin
                        r_state     <= S_HALTED;
                        r_step_done <= 1'b1;
                    end
                end
                default: r_state <= S_HALTED;
            endcase
        end
    end

    assign o_halt      = (r_state == S_HALTED);
    assign o_running   = (r_state == S_RUN);
    assign o_step_done = r_step_done;

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control with DEBOUNCE_CYCLES=4; expected values are
// hand-derived from the button latency and step sequencing rules.
module tb_run_control;

    logic clk;
    logic rst;
    logic btn_run_n;
    logic btn_step_n;
    logic hlt;
    logic cpu_clk;
    logic halt;
    logic running;
    logic step_done;

    int n_checks;
    int n_errors;

    run_control #(
        .DEBOUNCE_CYCLES(4)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_btn_run_n  (btn_run_n),
        .i_btn_step_n (btn_step_n),
        .i_hlt        (hlt),
        .i_cpu_clk    (cpu_clk),
        .o_halt       (halt),
        .o_running    (running),
        .o_step_done  (step_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n active edges, then settle 1 time unit so outputs are stable
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        btn_run_n  = 1'b1;
        btn_step_n = 1'b1;
        hlt        = 1'b0;
        cpu_clk    = 1'b0;

        // Reset state, then idle hold
        tick(2);
        rst = 1'b0;
        check_eq("reset_halt", 32'(halt), 32'd1);
        check_eq("reset_running", 32'(running), 32'd0);
        check_eq("reset_step_done", 32'(step_done), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_eq("idle_halt", 32'(halt), 32'd1);
            check_eq("idle_running", 32'(running), 32'd0);
        end

        // Run press: no change at edge 6, RUN at edge 7
        btn_run_n = 1'b0;
        tick(6);
        check_eq("run_edge6_halt", 32'(halt), 32'd1);
        tick(1);
        check_eq("run_edge7_halt", 32'(halt), 32'd0);
        check_eq("run_edge7_running", 32'(running), 32'd1);
        tick(3);
        btn_run_n = 1'b1;
        tick(10);
        check_eq("run_release_running", 32'(running), 32'd1);

        // Second run press stops at edge 7
        btn_run_n = 1'b0;
        tick(6);
        check_eq("stop_edge6_running", 32'(running), 32'd1);
        tick(1);
        check_eq("stop_edge7_halt", 32'(halt), 32'd1);
        check_eq("stop_edge7_running", 32'(running), 32'd0);
        btn_run_n = 1'b1;
        tick(10);

        // Glitches of 1..3 cycles never produce an event
        for (int rep = 0; rep < 2; rep++) begin
            for (int len = 1; len <= 3; len++) begin
                btn_run_n = 1'b0;
                tick(len);
                btn_run_n = 1'b1;
                tick(5);
                check_eq("glitch_halt", 32'(halt), 32'd1);
            end
        end
        tick(10);
        check_eq("glitch_final_running", 32'(running), 32'd0);

        // Single step with a run press ignored mid-step
        btn_step_n = 1'b0;
        tick(6);
        check_eq("step_edge6_halt", 32'(halt), 32'd1);
        tick(1);
        check_eq("step_edge7_halt", 32'(halt), 32'd0);
        check_eq("step_edge7_running", 32'(running), 32'd0);
        btn_step_n = 1'b1;
        btn_run_n  = 1'b0;
        tick(8);
        check_eq("step_runpress_halt", 32'(halt), 32'd0);
        check_eq("step_runpress_running", 32'(running), 32'd0);
        btn_run_n = 1'b1;
        cpu_clk   = 1'b1;
        tick(1);
        check_eq("step_rise_halt", 32'(halt), 32'd0);
        check_eq("step_rise_done", 32'(step_done), 32'd0);
        tick(4);
        check_eq("step_high_halt", 32'(halt), 32'd0);
        cpu_clk = 1'b0;
        tick(1);
        check_eq("step_fall_halt", 32'(halt), 32'd1);
        check_eq("step_fall_done", 32'(step_done), 32'd1);
        tick(1);
        check_eq("step_after_done", 32'(step_done), 32'd0);
        check_eq("step_after_halt", 32'(halt), 32'd1);
        tick(10);
        check_eq("step_end_running", 32'(running), 32'd0);
        check_eq("step_end_halt", 32'(halt), 32'd1);

        // HLT stops RUN next edge; presses ignored while HLT=1
        btn_run_n = 1'b0;
        tick(7);
        check_eq("hlt_run_running", 32'(running), 32'd1);
        btn_run_n = 1'b1;
        tick(10);
        hlt = 1'b1;
        tick(1);
        check_eq("hlt_halt", 32'(halt), 32'd1);
        check_eq("hlt_running", 32'(running), 32'd0);
        btn_run_n = 1'b0;
        tick(8);
        btn_run_n = 1'b1;
        tick(10);
        check_eq("hlt_runpress_halt", 32'(halt), 32'd1);
        btn_step_n = 1'b0;
        tick(8);
        btn_step_n = 1'b1;
        tick(10);
        check_eq("hlt_steppress_halt", 32'(halt), 32'd1);
        check_eq("hlt_steppress_running", 32'(running), 32'd0);
        hlt = 1'b0;
        tick(2);

        // Reset while in STEP_FALL: halted, no done pulse
        btn_step_n = 1'b0;
        tick(7);
        check_eq("rst_step_halt", 32'(halt), 32'd0);
        btn_step_n = 1'b1;
        tick(8);
        cpu_clk = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(1);
        check_eq("rst_mid_halt", 32'(halt), 32'd1);
        check_eq("rst_mid_done", 32'(step_done), 32'd0);
        rst     = 1'b0;
        cpu_clk = 1'b0;
        tick(1);
        check_eq("rst_after_done", 32'(step_done), 32'd0);
        check_eq("rst_after_halt", 32'(halt), 32'd1);
        tick(5);

        // Simultaneous run and step from HALTED: run wins
        btn_run_n  = 1'b0;
        btn_step_n = 1'b0;
        tick(7);
        check_eq("both_running", 32'(running), 32'd1);
        check_eq("both_halt", 32'(halt), 32'd0);
        btn_run_n  = 1'b1;
        btn_step_n = 1'b1;
        tick(10);
        check_eq("both_end_running", 32'(running), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
